// File: rtl/smem_bank_unit.sv
// ---------------------------------------------------------------------------
// smem_bank_unit
//   One 256x8 shared-memory bank with a built-in 16-core round-robin
//   arbiter. Each instance sees the request buses of all 16 cores. It serves
//   only the requests whose address selects its own bank number, one core at
//   a time. Read data returns on the core's byte lane, and a one-cycle
//   finish pulse goes to that core.
//
// Ports
//   clock     in   1    system clock, rising-edge
//   reset     in   1    asynchronous, active-low reset
//   read      in   16   per-core read request
//   write     in   16   per-core write request (wins over read)
//   bank_n    in   4    this bank's number, static after reset
//   addr_in   in   192  core c address at [12c+11:12c]; [12c+11:12c+8] = bank
//   data_in   in   128  core c write data at [8c+7:8c]
//   data_out  out  128  core c read data at [8c+7:8c], registered
//   finish    out  16   one-hot completion pulse, registered
//
// Optional build macro
//   SMEM_BANK_TRACE_EN : simulation-only per-cycle trace output
// ---------------------------------------------------------------------------
module smem_bank_unit (
  input  logic         clock,
  input  logic         reset,
  input  logic [15:0]  read,
  input  logic [15:0]  write,
  input  logic [3:0]   bank_n,
  input  logic [191:0] addr_in,
  input  logic [127:0] data_in,
  output logic [127:0] data_out,
  output logic [15:0]  finish
);

  logic [3:0]   ptr_r;
  logic         done_r;
  logic [7:0]   rdata_r;
  logic [7:0]   mem_r [0:255];
  logic [15:0]  finish_r;
  logic [127:0] data_out_r;

  logic [11:0]  core_addr_s [16];
  logic [7:0]   core_data_s [16];
  logic [15:0]  req_s;
  logic [11:0]  cur_addr_s;
  logic [7:0]   cur_wdata_s;
  logic         match_s;
  logic         serv_s;
  logic [3:0]   ptr_nxt_s;
  logic [3:0]   cand_s;
  logic         found_s;

  // Unpack the flat per-core buses into per-core arrays.
  always_comb begin
    for (int c = 0; c < 16; c++) begin
      core_addr_s[c] = addr_in[c*12 +: 12];
      core_data_s[c] = data_in[c*8 +: 8];
    end
  end

  // Request, bank match and service qualification for the current pointer.
  always_comb begin
    req_s       = read | write;
    cur_addr_s  = core_addr_s[ptr_r];
    cur_wdata_s = core_data_s[ptr_r];
    match_s     = (cur_addr_s[11:8] == bank_n);
    serv_s      = req_s[ptr_r] & match_s & ~done_r;
  end

  // Round-robin search: first requester after ptr, with ptr itself last
  // (k = 16 wraps back to ptr). The pointer holds when nobody requests.
  always_comb begin
    ptr_nxt_s = ptr_r;
    found_s   = 1'b0;
    cand_s    = 4'd0;
    for (int k = 1; k <= 16; k++) begin
      cand_s = ptr_r + k[3:0];
      if (!found_s && req_s[cand_s]) begin
        ptr_nxt_s = cand_s;
        found_s   = 1'b1;
      end else begin
        ptr_nxt_s = ptr_nxt_s;
        found_s   = found_s;
      end
    end
  end

  // Arbiter pointer, done flag and read-data register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ptr_r   <= 4'd0;
      done_r  <= 1'b0;
      rdata_r <= 8'd0;
    end else if (serv_s) begin
      done_r <= 1'b1;
      if (!write[ptr_r]) begin
        rdata_r <= mem_r[cur_addr_s[7:0]];
      end
    end else begin
      done_r <= 1'b0;
      ptr_r  <= ptr_nxt_s;
    end
  end

  // Storage array; deliberately not reset so that contents survive reset.
  always_ff @(posedge clock) begin
    if (serv_s && write[ptr_r]) begin
      mem_r[cur_addr_s[7:0]] <= cur_wdata_s;
    end
  end

  // Completion pulse and read-data lane, both driven from the done cycle.
  // ptr_r still names the completed core here because it only moves on
  // this same edge. A write completion reloads the lane with the unchanged
  // rdata, which cores ignore.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      finish_r   <= 16'd0;
      data_out_r <= 128'd0;
    end else if (done_r) begin
      finish_r                       <= 16'd1 << ptr_r;
      data_out_r[{ptr_r, 3'b000} +: 8] <= rdata_r;
    end else begin
      finish_r <= 16'd0;
    end
  end

  assign finish   = finish_r;
  assign data_out = data_out_r;

`ifdef SMEM_BANK_TRACE_EN
  // One trace line per rising edge while out of reset.
  always @(posedge clock) begin
    if (reset) begin
      $display("bank=%h ptr=%h serv=%b rd=%b wr=%b addr=%h wdata=%h rdata=%h fin=%b t=%0t",
               bank_n, ptr_r, serv_s, read[ptr_r], write[ptr_r], cur_addr_s[7:0],
               cur_wdata_s, rdata_r, finish_r[ptr_r], $time);
    end
  end
`endif

endmodule

// File: tb/tb_smem_bank_unit.sv
module tb_smem_bank_unit;

  logic         clock;
  logic         reset;
  logic [15:0]  read;
  logic [15:0]  write;
  logic [3:0]   bank_n;
  logic [191:0] addr_in;
  logic [127:0] data_in;
  logic [127:0] data_out;
  logic [15:0]  finish;

  int errors = 0;
  int checks = 0;
  logic [127:0] exp_dout;

  smem_bank_unit dut (
    .clock    (clock),
    .reset    (reset),
    .read     (read),
    .write    (write),
    .bank_n   (bank_n),
    .addr_in  (addr_in),
    .data_in  (data_in),
    .data_out (data_out),
    .finish   (finish)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Raise one core's request and wait (bounded) for its finish pulse.
  task automatic run_req(input int c, input logic rd, input logic wr,
                         input logic [11:0] a, input logic [7:0] d,
                         output logic [15:0] fin, output int lat);
    read[c]  = rd;
    write[c] = wr;
    addr_in[c*12 +: 12] = a;
    data_in[c*8 +: 8]   = d;
    fin = 16'd0;
    lat = 0;
    while (fin == 16'd0 && lat < 40) begin
      tick();
      lat++;
      fin = finish;
    end
    read[c]  = 1'b0;
    write[c] = 1'b0;
  endtask

  initial begin
    logic [15:0] fin;
    logic [15:0] acc;
    logic [15:0] prev;
    logic [15:0] seq [4];
    int lat;
    int nfin;
    int b2b;

    reset    = 1'b0;
    read     = 16'd0;
    write    = 16'd0;
    bank_n   = 4'd3;
    addr_in  = 192'd0;
    data_in  = 128'd0;
    exp_dout = 128'd0;
    repeat (2) tick();
    chk("reset_finish", {112'd0, finish}, 128'd0);
    chk("reset_dout", data_out, 128'd0);
    reset = 1'b1;
    tick();

    // Core 0 writes 0xA5 to 0x312: finish two cycles after service.
    read[0] = 1'b0; write[0] = 1'b1;
    addr_in[11:0] = 12'h312; data_in[7:0] = 8'hA5;
    tick();
    chk("wr_cycle1_nofin", {112'd0, finish}, 128'd0);
    tick();
    chk("wr_finish", {112'd0, finish}, {112'd0, 16'h0001});
    write[0] = 1'b0;
    exp_dout[7:0] = 8'h00;  // rdata still the reset value
    chk("wr_lane0_reload", data_out, exp_dout);
    tick();
    chk("wr_pulse_single", {112'd0, finish}, 128'd0);

    // Core 0 reads 0x312 back.
    run_req(0, 1'b1, 1'b0, 12'h312, 8'h00, fin, lat);
    chk("rd_finish", {112'd0, fin}, {112'd0, 16'h0001});
    chk("rd_latency", lat, 2);
    exp_dout[7:0] = 8'hA5;
    chk("rd_data", data_out, exp_dout);

    // Core 5 targets bank 4: never served.
    read[5] = 1'b1; addr_in[5*12 +: 12] = 12'h412;
    acc = 16'd0;
    for (int i = 0; i < 10; i++) begin
      tick();
      acc = acc | finish;
    end
    chk("wrong_bank_nofin", {112'd0, acc}, 128'd0);
    // Core 6 in the right bank is reached past core 5.
    run_req(6, 1'b1, 1'b0, 12'h312, 8'h00, fin, lat);
    chk("skip_core6_finish", {112'd0, fin}, {112'd0, 16'h0040});
    chk("skip_core6_latency", lat, 3);
    exp_dout[6*8 +: 8] = 8'hA5;
    chk("skip_core6_data", data_out, exp_dout);
    read[5] = 1'b0;

    // Preload words for the contention test via core 0.
    run_req(0, 1'b0, 1'b1, 12'h301, 8'h11, fin, lat);
    chk("pre1_finish", {112'd0, fin}, {112'd0, 16'h0001});
    run_req(0, 1'b0, 1'b1, 12'h302, 8'h22, fin, lat);
    run_req(0, 1'b0, 1'b1, 12'h303, 8'h33, fin, lat);
    chk("pre3_finish", {112'd0, fin}, {112'd0, 16'h0001});
    chk("pre_lanes", data_out, exp_dout);

    // Contention: cores 2, 7, 15; core 2 stays requesting for a second visit.
    read[2] = 1'b1;  addr_in[2*12 +: 12]  = 12'h301;
    read[7] = 1'b1;  addr_in[7*12 +: 12]  = 12'h302;
    read[15] = 1'b1; addr_in[15*12 +: 12] = 12'h303;
    nfin = 0; b2b = 0; prev = 16'd0;
    for (int i = 0; i < 60 && nfin < 4; i++) begin
      tick();
      if (finish != 16'd0) begin
        if (prev != 16'd0) b2b++;
        seq[nfin] = finish;
        nfin++;
        if (finish[7]) read[7] = 1'b0;
        if (finish[15]) read[15] = 1'b0;
        if (nfin == 4) read[2] = 1'b0;
      end
      prev = finish;
    end
    read = 16'd0;
    chk("cont_count", nfin, 4);
    chk("cont_seq0", {112'd0, seq[0]}, {112'd0, 16'h0004});
    chk("cont_seq1", {112'd0, seq[1]}, {112'd0, 16'h0080});
    chk("cont_seq2", {112'd0, seq[2]}, {112'd0, 16'h8000});
    chk("cont_seq3", {112'd0, seq[3]}, {112'd0, 16'h0004});
    chk("cont_single_pulse", b2b, 0);
    exp_dout[2*8 +: 8]  = 8'h11;
    exp_dout[7*8 +: 8]  = 8'h22;
    exp_dout[15*8 +: 8] = 8'h33;
    chk("cont_lanes", data_out, exp_dout);

    // Core 4 asserts read and write together: the write wins.
    read[4] = 1'b1;
    run_req(4, 1'b1, 1'b1, 12'h3FF, 8'h3C, fin, lat);
    chk("rw_finish", {112'd0, fin}, {112'd0, 16'h0010});
    exp_dout[4*8 +: 8] = 8'h11;  // lane reloads the old rdata
    chk("rw_lanes", data_out, exp_dout);
    run_req(4, 1'b1, 1'b0, 12'h3FF, 8'h00, fin, lat);
    chk("rw_readback_fin", {112'd0, fin}, {112'd0, 16'h0010});
    exp_dout[4*8 +: 8] = 8'h3C;
    chk("rw_readback_data", data_out, exp_dout);

    // Reset in the cycle after service (core 1, pointer currently 4).
    read[1] = 1'b1; addr_in[1*12 +: 12] = 12'h312;
    tick();  // pointer moves to 1
    tick();  // service edge, done now high
    reset = 1'b0;
    #1;
    chk("rst_mid_finish", {112'd0, finish}, 128'd0);
    chk("rst_mid_dout", data_out, 128'd0);
    read[1] = 1'b0;
    tick();
    reset = 1'b1;
    exp_dout = 128'd0;
    acc = 16'd0;
    for (int i = 0; i < 5; i++) begin
      tick();
      acc = acc | finish;
    end
    chk("rst_no_late_finish", {112'd0, acc}, 128'd0);
    run_req(4, 1'b1, 1'b0, 12'h3FF, 8'h00, fin, lat);
    chk("rst_mem_kept_fin", {112'd0, fin}, {112'd0, 16'h0010});
    chk("rst_ptr_zero_latency", lat, 3);
    exp_dout[4*8 +: 8] = 8'h3C;
    chk("rst_mem_kept_data", data_out, exp_dout);

    // Idle for 20 cycles.
    acc = 16'd0;
    for (int i = 0; i < 20; i++) begin
      tick();
      acc = acc | finish;
    end
    chk("idle_finish", {112'd0, acc}, 128'd0);
    chk("idle_dout", data_out, exp_dout);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
